// File: rtl/mem_line_responder.sv
// mem_line_responder: memory-side responder for line fills and write-backs.
// One request at a time. Each request is answered LATENCY cycles after it is
// accepted, and the next request is not taken until the response handshake.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. Once valid is raised, the sender holds valid
// and payload stable until that edge. Ready may rise or fall freely.
`timescale 1ns/1ps
module mem_line_responder #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_write,
   output logic [LINE_W-1:0] resp_rdata,
   output logic              busy
);

   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state;
   logic [CNT_W-1:0]  count;
   logic              write_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] mem [DEPTH];

   logic              accept;
   logic              commit;
   logic [IDX_W-1:0]  req_idx;
   logic              unused_addr;

   // Offset bits and bits above the index are don't-care: lines alias modulo DEPTH.
   assign req_idx     = req_addr[OFF_W +: IDX_W];
   assign unused_addr = ^{req_addr[ADDR_W-1:OFF_W+IDX_W], req_addr[OFF_W-1:0]};

   // accept: request taken this edge; commit: the latency has run out this edge.
   // Both derive from the async-reset state, so a reset in WAIT suppresses commit.
   assign accept = (state == S_IDLE) && req_valid;
   assign commit = (state == S_WAIT) && (count == '0);

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign busy       = (state != S_IDLE);

   // Control FSM plus latched request and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         count      <= '0;
         write_q    <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         resp_write <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  write_q <= req_write;
                  idx_q   <= req_idx;
                  wdata_q <= req_wdata;
                  count   <= CNT_W'(LATENCY - 1);
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (commit) begin
                  resp_rdata <= write_q ? wdata_q : mem[idx_q];
                  resp_write <= write_q;
                  state      <= S_RESP;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Backing array: not cleared by reset; a write lands on the WAIT->RESP edge.
   always_ff @(posedge clk) begin
      if (commit && write_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_line_responder.sv
// Testbench for mem_line_responder: directed scenarios followed by random
// read/write traffic, checked against a line-indexed reference memory.
`timescale 1ns/1ps
module tb_mem_line_responder;

   localparam int LAT = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main instance (LATENCY = 5)
   logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic         resp_valid, resp_ready = 1'b0, resp_write, busy;
   logic [127:0] resp_rdata;

   mem_line_responder #(.ADDR_W(32), .LINE_W(128), .DEPTH(4096), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
      .resp_rdata(resp_rdata), .busy(busy)
   );

   // second instance (LATENCY = 1)
   logic         b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
   logic [31:0]  b_req_addr = '0;
   logic [127:0] b_req_wdata = '0;
   logic         b_resp_valid, b_resp_ready = 1'b0, b_resp_write, b_busy;
   logic [127:0] b_resp_rdata;

   mem_line_responder #(.ADDR_W(32), .LINE_W(128), .DEPTH(4096), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_write(b_resp_write),
      .resp_rdata(b_resp_rdata), .busy(b_busy)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_assert = 0;
   int n_fail   = 0;
   logic [127:0] exp_q[$];
   logic [127:0] model_mem [int];

   function automatic int line_of(input logic [31:0] addr);
      return int'((addr / 32'd16) % 32'd4096);
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"},  req_ready,  1'b1);
      check({tag, " resp_valid"}, resp_valid, 1'b0);
      check({tag, " resp_write"}, resp_write, 1'b0);
      check({tag, " resp_rdata"}, resp_rdata, 128'h0);
      check({tag, " busy"},       busy,       1'b0);
   endtask

   // ---------------- driver ----------------
   // Issue one request, check latency and response, hold the response for
   // 'hold' cycles, then complete the handshake.
   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                         input int hold, input string tag);
      int n;
      int line;
      logic [127:0] exp;
      logic [127:0] held;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, " req_ready"}, req_ready, 1'b1);
      line = line_of(addr);
      if (wr) begin
         model_mem[line] = data;
         exp_q.push_back(data);
      end else begin
         exp_q.push_back(model_mem[line]);
      end
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = {4{$urandom}};
      check({tag, " busy_after_accept"}, busy, 1'b1);
      check({tag, " ready_after_accept"}, req_ready, 1'b0);
      n = 0;
      while (!resp_valid && n < 50) begin
         // resp_ready without resp_valid must be ignored
         resp_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1; n++;
         if (!resp_valid) check({tag, " busy_wait"}, busy, 1'b1);
      end
      resp_ready = 1'b0;
      check({tag, " latency"}, n, LAT);
      exp = exp_q.pop_front();
      check({tag, " rdata"}, resp_rdata, exp);
      check({tag, " resp_write"}, resp_write, wr);
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, " hold_valid"}, resp_valid, 1'b1);
         check({tag, " hold_rdata"}, resp_rdata, held);
         check({tag, " hold_ready"}, req_ready, 1'b0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, " valid_after_hs"}, resp_valid, 1'b0);
      check({tag, " ready_after_hs"}, req_ready, 1'b1);
      check({tag, " busy_after_hs"}, busy, 1'b0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [127:0] line3, pat_a, pat_55, pat_new, alias_d, rnd_d;
   logic [31:0]  rnd_a;
   logic         rnd_w;
   int           rnd_line;

   initial begin
      line3   = 128'h0123456789ABCDEF0123456789ABCDEF;
      pat_a   = {16{8'hAA}};
      pat_55  = {16{8'h55}};
      pat_new = {4{$urandom}};
      alias_d = {4{$urandom}};

      // reset values while reset is held
      #12;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("post_reset");

      // preload line 3, read it back through 0x30
      do_req(1'b1, 32'h30, line3, 0, "preload3");
      do_req(1'b0, 32'h30, '0, 0, "read3");

      // write 0x40, read 0x4C: offset bits ignored
      do_req(1'b1, 32'h40, pat_a, 0, "write40");
      do_req(1'b0, 32'h4C, '0, 0, "read4c");

      // response held for 10 cycles
      do_req(1'b0, 32'h44, '0, 10, "hold");

      // reset two cycles after accepting a write to line 7: write is dropped
      do_req(1'b1, 32'h70, pat_55, 0, "write7_old");
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h70; req_wdata = pat_new;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_in_wait");
      @(posedge clk); #1;
      rst = 1'b0;
      do_req(1'b0, 32'h7C, '0, 0, "read7_after_rst");

      // aliasing modulo DEPTH lines
      do_req(1'b1, 32'h0001_0010, alias_d, 0, "alias_write");
      do_req(1'b0, 32'h10, '0, 0, "alias_read");

      // random traffic over 16 lines with random offsets and high bits
      for (int t = 0; t < 40; t++) begin
         rnd_line = $urandom_range(0, 15);
         rnd_a    = ($urandom & 32'hFFFF_0000) | (32'(rnd_line) << 4) | 32'($urandom_range(0, 15));
         rnd_w    = !model_mem.exists(rnd_line) || ($urandom_range(0, 1) == 1);
         rnd_d    = {4{$urandom}};
         do_req(rnd_w, rnd_a, rnd_d, $urandom_range(0, 3), "random");
      end

      // LATENCY = 1 instance: request held, resp_ready tied high -> one accept
      // every 3 cycles; response visible one cycle after each accept
      b_req_wdata  = {4{$urandom}};
      b_req_write  = 1'b1;
      b_req_addr   = 32'h200;
      b_req_valid  = 1'b1;
      b_resp_ready = 1'b1;
      for (int s = 0; s < 12; s++) begin
         check("lat1 req_ready", b_req_ready, (s % 3) == 0);
         check("lat1 resp_valid", b_resp_valid, (s % 3) == 2);
         if ((s % 3) == 2) check("lat1 rdata", b_resp_rdata, b_req_wdata);
         @(posedge clk); #1;
      end
      b_req_valid  = 1'b0;
      b_resp_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
